multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 The module SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- instr  in  32  instruction word from instruction memory, valid when im_ready=1.
- im_ready  in  1  instruction memory has data.
- dm_ready  in  1  data memory access complete.
- br_taken  in  1  branch condition from ALU compare, sampled in EXEC.
- im_req  out  1  instruction fetch request.
- ir_write  out  1  latch instr into IR.
- ImmType  out  3  immediate format select to the immediate generator.
- alu_src  out  1  0=rs2, 1=immediate.
- dm_req  out  1  data memory request.
- dm_we  out  1  data memory write.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  00=ALU, 01=load data, 10=PC+4.
- pc_write  out  1  PC update enable.
- pc_sel  out  2  00=PC+4, 01=PC+imm, 10=(rs1+imm)&~1.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- instret  out  32  retired-instruction counter.

Function
REQ-003 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB; all outputs except instret SHALL be Moore, decoded from state and the latched opcode.
REQ-004 FETCH: im_req=1 until im_ready=1. On that cycle ir_write=1, opcode instr[6:0] is latched, and the next state is DECODE. With im_ready=0 the FSM stays in FETCH with no other outputs asserted.
REQ-005 DECODE SHALL register ImmType from the latched opcode:
- LOAD/OP-IMM/JALR -> I=000
- STORE -> S=001
- BRANCH -> B=010
- LUI/AUIPC -> U=011
- JAL -> J=100
- R-type -> 000 (don't-care)
ImmType SHALL hold until the next DECODE.
REQ-006 DECODE with an unknown opcode SHALL pulse illegal for one cycle, go to FETCH with pc_write=1 and pc_sel=00, and not increment instret.
REQ-007 EXEC SHALL set alu_src=1 for every opcode except R-type and BRANCH. Next state:
- LOAD/STORE -> MEM
- BRANCH -> FETCH, with pc_write=1 and pc_sel=01 if br_taken else 00
- all others -> WB
REQ-008 MEM: dm_req=1, with dm_we=1 for STORE, until dm_ready=1. Then LOAD -> WB; STORE -> FETCH with pc_write=1, pc_sel=00.
REQ-009 WB SHALL drive reg_write=1 and pc_write=1, then go to FETCH:
- wb_sel=01 for LOAD, 10 for JAL/JALR, 00 otherwise
- pc_sel=01 for JAL, 10 for JALR, 00 otherwise
REQ-010 pc_write SHALL be asserted exactly once per instruction, in its final cycle.
REQ-011 instret SHALL increment by 1 in the cycle pc_write=1 for a legal instruction, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-012 Latency (zero memory wait states) SHALL be:
- BRANCH 3 cycles
- STORE 4 cycles
- R/I/U/J 4 cycles
- LOAD 5 cycles
Each wait cycle adds exactly 1.
REQ-013 im_ready while not in FETCH, or dm_ready while not in MEM, SHALL be ignored.

Reset
REQ-014 While rst=1, the state SHALL be forced to FETCH, every output SHALL be 0 (including ImmType=000 and instret=0), and im_req SHALL stay 0.
REQ-015 The first cycle after rst falls, im_req SHALL be 1.
REQ-016 A reset mid-instruction (any state, including mid-wait) SHALL abort it in the same edge, with no pc_write, reg_write or instret increment.

Structure
REQ-017 A shared package SHALL hold: the state enum, the opcode constants, the ImmType encodings (I=000, S=001, B=010, U=011, J=100), and the wb_sel/pc_sel encodings.
REQ-018 One combinational sub-module, imm_type_decode (opcode -> ImmType, legal), SHALL be instantiated. All other logic stays in multicycle_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ADDI 0x00500093 with im_ready high: ImmType=000, alu_src=1, reg_write in cycle 4, instret 0->1.
- LW with dm_ready delayed 3 cycles: dm_req high for 4 cycles, wb_sel=01, reg_write in cycle 8.
- BEQ: br_taken=1 gives pc_sel=01, pc_write in cycle 3, ImmType=010; br_taken=0 gives pc_sel=00.
- JAL 0x008000EF: ImmType=100, wb_sel=10, pc_sel=01. JALR: pc_sel=10, ImmType=000.
- Opcode 0x7F: illegal pulses 1 cycle, instret unchanged, FSM returns to FETCH.
- rst asserted during a MEM wait: next cycle all outputs 0 and no reg_write. After release, im_req=1 and instret=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: states, opcodes,
// immediate formats and the write-back / next-PC mux selects.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

endpackage

// File: rtl/imm_type_decode.sv
// Opcode to immediate-format decode; also flags whether the opcode is one
// the controller knows how to sequence.
module imm_type_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_type,
  output logic       legal
);

  always_comb begin
    imm_type = IMM_I;
    legal    = 1'b1;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_type = IMM_I;
      OPC_STORE:                      imm_type = IMM_S;
      OPC_BRANCH:                     imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_type = IMM_U;
      OPC_JAL:                        imm_type = IMM_J;
      OPC_OP:                         imm_type = IMM_I;
      default:                        legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with retired-instruction counter.
//   state  | meaning
//   FETCH  | request instruction, latch opcode when im_ready
//   DECODE | register ImmType; unknown opcode retires as illegal
//   EXEC   | ALU operand select; branches resolve here
//   MEM    | data memory access until dm_ready
//   WB     | register write-back and PC update
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        im_ready,
  input  logic        dm_ready,
  input  logic        br_taken,
  output logic        im_req,
  output logic        ir_write,
  output logic [2:0]  ImmType,
  output logic        alu_src,
  output logic        dm_req,
  output logic        dm_we,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t      state_q;
  logic [6:0]  opcode_q;
  logic [2:0]  imm_type_q;
  logic [31:0] instret_q;
  logic [2:0]  dec_imm_type;
  logic        op_legal;
  logic        unused_instr;

  assign unused_instr = ^instr[31:7];

  imm_type_decode u_imm_type_decode (
    .opcode   (opcode_q),
    .imm_type (dec_imm_type),
    .legal    (op_legal)
  );

  logic is_load, is_store, is_branch, is_op, is_jal, is_jalr;
  assign is_load   = (opcode_q == OPC_LOAD);
  assign is_store  = (opcode_q == OPC_STORE);
  assign is_branch = (opcode_q == OPC_BRANCH);
  assign is_op     = (opcode_q == OPC_OP);
  assign is_jal    = (opcode_q == OPC_JAL);
  assign is_jalr   = (opcode_q == OPC_JALR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      opcode_q   <= '0;
      imm_type_q <= IMM_I;
      instret_q  <= '0;
    end else begin
      if (pc_write && op_legal)
        instret_q <= instret_q + 32'd1;
      case (state_q)
        ST_FETCH:
          if (im_ready) begin
            opcode_q <= instr[6:0];
            state_q  <= ST_DECODE;
          end
        ST_DECODE: begin
          imm_type_q <= dec_imm_type;
          state_q    <= op_legal ? ST_EXEC : ST_FETCH;
        end
        ST_EXEC:
          if (is_load || is_store) state_q <= ST_MEM;
          else if (is_branch)      state_q <= ST_FETCH;
          else                     state_q <= ST_WB;
        ST_MEM:
          if (dm_ready) state_q <= is_load ? ST_WB : ST_FETCH;
        ST_WB:
          state_q <= ST_FETCH;
        default:
          state_q <= ST_FETCH;
      endcase
    end
  end

  // Handshake completions (im_ready, dm_ready, br_taken) act in the same
  // cycle so the zero-wait latencies come out at 3/4/5 cycles.
  always_comb begin
    im_req    = 1'b0;
    ir_write  = 1'b0;
    alu_src   = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    pc_write  = 1'b0;
    pc_sel    = PC_PLUS4;
    illegal   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          im_req   = 1'b1;
          ir_write = im_ready;
        end
        ST_DECODE:
          if (!op_legal) begin
            illegal  = 1'b1;
            pc_write = 1'b1;
          end
        ST_EXEC: begin
          alu_src = !(is_op || is_branch);
          if (is_branch) begin
            pc_write = 1'b1;
            pc_sel   = br_taken ? PC_IMM : PC_PLUS4;
          end
        end
        ST_MEM: begin
          dm_req   = 1'b1;
          dm_we    = is_store;
          pc_write = is_store && dm_ready;
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          if (is_load)                wb_sel = WB_LOAD;
          else if (is_jal || is_jalr) wb_sel = WB_PC4;
          if (is_jal)       pc_sel = PC_IMM;
          else if (is_jalr) pc_sel = PC_JALR;
        end
        default: ;
      endcase
    end
  end

  assign ImmType = rst ? 3'b000 : imm_type_q;
  assign instret = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; outputs are packed per cycle as
// {im_req,ir_write,alu_src,dm_req,dm_we,reg_write,pc_write,illegal,ImmType,wb_sel,pc_sel}.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        im_ready = 1'b0, dm_ready = 1'b0, br_taken = 1'b0;
  logic        im_req, ir_write, alu_src, dm_req, dm_we, reg_write;
  logic        pc_write, illegal;
  logic [2:0]  ImmType;
  logic [1:0]  wb_sel, pc_sel;
  logic [31:0] instret;

  int          n_vec = 0;
  int          n_err = 0;
  logic [2:0]  prev_it = 3'b000;
  logic [31:0] exp_instret = 32'd0;
  localparam logic [14:0] MASK_IT = 15'h7F8F;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .im_ready(im_ready),
    .dm_ready(dm_ready), .br_taken(br_taken), .im_req(im_req),
    .ir_write(ir_write), .ImmType(ImmType), .alu_src(alu_src),
    .dm_req(dm_req), .dm_we(dm_we), .reg_write(reg_write),
    .wb_sel(wb_sel), .pc_write(pc_write), .pc_sel(pc_sel),
    .illegal(illegal), .instret(instret)
  );

  function automatic logic [14:0] outs();
    return {im_req, ir_write, alu_src, dm_req, dm_we, reg_write, pc_write,
            illegal, ImmType, wb_sel, pc_sel};
  endfunction

  function automatic logic [14:0] e(input logic [7:0] f, input logic [2:0] it,
                                    input logic [1:0] wb, input logic [1:0] ps);
    return {f, it, wb, ps};
  endfunction

  // Apply inputs just after a rising edge, then move to the falling edge.
  task automatic cyc(input logic [2:0] s, input logic [31:0] ins);
    instr    = ins;
    im_ready = s[2];
    dm_ready = s[1];
    br_taken = s[0];
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(3'b111, 32'h00500093);
      n_vec++;
      if (outs() !== 15'h0000) begin
        n_err++;
        $display("FAIL reset_outs cyc%0d: got %h want %h", c, outs(), 15'h0000);
      end
      n_vec++;
      if (instret !== 32'd0) begin
        n_err++;
        $display("FAIL reset_instret cyc%0d: got %0d want 0", c, instret);
      end
      adv();
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    logic [14:0] want [4];
    want = '{e(8'b1100_0000, prev_it, 2'b00, 2'b00),
             e(8'b0000_0000, prev_it, 2'b00, 2'b00),
             e(8'b0010_0000, 3'b000,  2'b00, 2'b00),
             e(8'b0000_0110, 3'b000,  2'b00, 2'b00)};
    for (int c = 0; c < 4; c++) begin
      cyc(3'b100, (c == 0) ? 32'h00500093 : 32'hFFFFFFFF);
      n_vec++;
      if (outs() !== want[c]) begin
        n_err++;
        $display("FAIL addi cyc%0d: got %h want %h", c + 1, outs(), want[c]);
      end
      adv();
    end
    exp_instret = exp_instret + 32'd1;
    n_vec++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL addi_instret: got %0d want %0d", instret, exp_instret);
    end
    prev_it = 3'b000;
  endtask

  task automatic test_load_wait();
    logic [2:0]  stim [8];
    logic [14:0] want [8];
    stim = '{3'b110, 3'b110, 3'b110, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010};
    want = '{e(8'b1100_0000, prev_it, 2'b00, 2'b00),
             e(8'b0000_0000, prev_it, 2'b00, 2'b00),
             e(8'b0010_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0001_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0001_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0001_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0001_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0000_0110, 3'b000, 2'b01, 2'b00)};
    for (int c = 0; c < 8; c++) begin
      cyc(stim[c], (c == 0) ? 32'h0000A103 : 32'h00000000);
      n_vec++;
      if (outs() !== want[c]) begin
        n_err++;
        $display("FAIL lw cyc%0d: got %h want %h", c + 1, outs(), want[c]);
      end
      adv();
    end
    exp_instret = exp_instret + 32'd1;
    n_vec++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL lw_instret: got %0d want %0d", instret, exp_instret);
    end
    prev_it = 3'b000;
  endtask

  task automatic test_store_fetch_wait();
    logic [2:0]  stim [6];
    logic [14:0] want [6];
    stim = '{3'b010, 3'b010, 3'b110, 3'b010, 3'b010, 3'b010};
    want = '{e(8'b1000_0000, prev_it, 2'b00, 2'b00),
             e(8'b1000_0000, prev_it, 2'b00, 2'b00),
             e(8'b1100_0000, prev_it, 2'b00, 2'b00),
             e(8'b0000_0000, prev_it, 2'b00, 2'b00),
             e(8'b0010_0000, 3'b001, 2'b00, 2'b00),
             e(8'b0001_1010, 3'b001, 2'b00, 2'b00)};
    for (int c = 0; c < 6; c++) begin
      cyc(stim[c], (c < 2) ? 32'h00500093 : 32'h0020A023);
      n_vec++;
      if (outs() !== want[c]) begin
        n_err++;
        $display("FAIL sw cyc%0d: got %h want %h", c + 1, outs(), want[c]);
      end
      adv();
    end
    exp_instret = exp_instret + 32'd1;
    n_vec++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL sw_instret: got %0d want %0d", instret, exp_instret);
    end
    prev_it = 3'b001;
  endtask

  task automatic test_branch();
    logic [2:0]  stim [6];
    logic [14:0] want [6];
    stim = '{3'b101, 3'b001, 3'b001, 3'b100, 3'b000, 3'b000};
    want = '{e(8'b1100_0000, prev_it, 2'b00, 2'b00),
             e(8'b0000_0000, prev_it, 2'b00, 2'b00),
             e(8'b0000_0010, 3'b010, 2'b00, 2'b01),
             e(8'b1100_0000, 3'b010, 2'b00, 2'b00),
             e(8'b0000_0000, 3'b010, 2'b00, 2'b00),
             e(8'b0000_0010, 3'b010, 2'b00, 2'b00)};
    for (int c = 0; c < 6; c++) begin
      cyc(stim[c], 32'h00208463);
      n_vec++;
      if (outs() !== want[c]) begin
        n_err++;
        $display("FAIL beq cyc%0d: got %h want %h", c + 1, outs(), want[c]);
      end
      adv();
    end
    exp_instret = exp_instret + 32'd2;
    n_vec++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL beq_instret: got %0d want %0d", instret, exp_instret);
    end
    prev_it = 3'b010;
  endtask

  task automatic test_jumps();
    logic [31:0] ins  [8];
    logic [14:0] want [8];
    ins  = '{32'h008000EF, 32'h0, 32'h0, 32'h0, 32'h000080E7, 32'h0, 32'h0, 32'h0};
    want = '{e(8'b1100_0000, prev_it, 2'b00, 2'b00),
             e(8'b0000_0000, prev_it, 2'b00, 2'b00),
             e(8'b0010_0000, 3'b100, 2'b00, 2'b00),
             e(8'b0000_0110, 3'b100, 2'b10, 2'b01),
             e(8'b1100_0000, 3'b100, 2'b00, 2'b00),
             e(8'b0000_0000, 3'b100, 2'b00, 2'b00),
             e(8'b0010_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0000_0110, 3'b000, 2'b10, 2'b10)};
    for (int c = 0; c < 8; c++) begin
      cyc((c % 4 == 0) ? 3'b100 : 3'b000, ins[c]);
      n_vec++;
      if (outs() !== want[c]) begin
        n_err++;
        $display("FAIL jal_jalr cyc%0d: got %h want %h", c + 1, outs(), want[c]);
      end
      adv();
    end
    exp_instret = exp_instret + 32'd2;
    n_vec++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL jump_instret: got %0d want %0d", instret, exp_instret);
    end
    prev_it = 3'b000;
  endtask

  task automatic test_rtype_lui();
    logic [31:0] ins  [8];
    logic [14:0] want [8];
    ins  = '{32'h002081B3, 32'h0, 32'h0, 32'h0, 32'h123450B7, 32'h0, 32'h0, 32'h0};
    want = '{e(8'b1100_0000, prev_it, 2'b00, 2'b00),
             e(8'b0000_0000, prev_it, 2'b00, 2'b00),
             e(8'b0000_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0000_0110, 3'b000, 2'b00, 2'b00),
             e(8'b1100_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0000_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0010_0000, 3'b011, 2'b00, 2'b00),
             e(8'b0000_0110, 3'b011, 2'b00, 2'b00)};
    for (int c = 0; c < 8; c++) begin
      cyc((c % 4 == 0) ? 3'b100 : 3'b000, ins[c]);
      n_vec++;
      if (outs() !== want[c]) begin
        n_err++;
        $display("FAIL add_lui cyc%0d: got %h want %h", c + 1, outs(), want[c]);
      end
      adv();
    end
    exp_instret = exp_instret + 32'd2;
    n_vec++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL add_lui_instret: got %0d want %0d", instret, exp_instret);
    end
    prev_it = 3'b011;
  endtask

  task automatic test_illegal();
    logic [14:0] want [4];
    logic [14:0] m;
    want = '{e(8'b1100_0000, prev_it, 2'b00, 2'b00),
             e(8'b0000_0011, prev_it, 2'b00, 2'b00),
             e(8'b1000_0000, 3'b000, 2'b00, 2'b00),
             e(8'b1000_0000, 3'b000, 2'b00, 2'b00)};
    for (int c = 0; c < 4; c++) begin
      cyc((c == 0) ? 3'b100 : 3'b000, 32'h0000007F);
      m = (c < 2) ? 15'h7FFF : MASK_IT;
      n_vec++;
      if ((outs() & m) !== (want[c] & m)) begin
        n_err++;
        $display("FAIL illegal cyc%0d: got %h want %h", c + 1, outs() & m, want[c] & m);
      end
      adv();
    end
    n_vec++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL illegal_instret: got %0d want %0d", instret, exp_instret);
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [2:0]  stim [5];
    logic [14:0] want [5];
    logic [14:0] m;
    stim = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    want = '{e(8'b1100_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0000_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0010_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0001_0000, 3'b000, 2'b00, 2'b00),
             e(8'b0001_0000, 3'b000, 2'b00, 2'b00)};
    for (int c = 0; c < 5; c++) begin
      cyc(stim[c], 32'h0000A103);
      m = (c < 2) ? MASK_IT : 15'h7FFF;
      n_vec++;
      if ((outs() & m) !== (want[c] & m)) begin
        n_err++;
        $display("FAIL rst_mid cyc%0d: got %h want %h", c + 1, outs() & m, want[c] & m);
      end
      adv();
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cyc(3'b111, 32'h0000A103);
      n_vec++;
      if (outs() !== 15'h0000 || instret !== 32'd0) begin
        n_err++;
        $display("FAIL rst_mid_hold cyc%0d: got %h/%0d want 0000/0", c, outs(), instret);
      end
      adv();
    end
    rst = 1'b0;
    exp_instret = 32'd0;
    cyc(3'b010, 32'h0);
    n_vec++;
    if (outs() !== e(8'b1000_0000, 3'b000, 2'b00, 2'b00)) begin
      n_err++;
      $display("FAIL rst_release: got %h want %h", outs(), e(8'b1000_0000, 3'b000, 2'b00, 2'b00));
    end
    n_vec++;
    if (instret !== exp_instret) begin
      n_err++;
      $display("FAIL rst_release_instret: got %0d want %0d", instret, exp_instret);
    end
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_addi();
    test_load_wait();
    test_store_fetch_wait();
    test_branch();
    test_jumps();
    test_rtype_lui();
    test_illegal();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
